// File: rtl/ram8_bist.sv
// rtl/ram8_bist.sv - RAM8 built-in self-test sequencer
// Writes seed+address to every word, reads back, then repeats inverted.
module ram8_bist #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int ERR_WIDTH  = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_seed,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0] o_in,
  output logic                  o_load,
  input  logic [DATA_WIDTH-1:0] i_out,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [ERR_WIDTH-1:0]  o_error_count,
  output logic [ADDR_WIDTH-1:0] o_fail_address,
  output logic                  o_fail_phase
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ERR_WIDTH-1:0] ERR_MAX = ERR_WIDTH'(2 * DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t                r_state, w_state;
  logic                  r_phase, w_phase;
  logic [DATA_WIDTH-1:0] r_seed, w_seed;
  logic [ADDR_WIDTH-1:0] r_address, w_address;
  logic [DATA_WIDTH-1:0] r_in, w_in;
  logic                  r_load, w_load;
  logic [ERR_WIDTH-1:0]  r_err, w_err;
  logic [ADDR_WIDTH-1:0] r_fail_addr, w_fail_addr;
  logic                  r_fail_phase, w_fail_phase;

  logic                  w_last;
  logic                  w_mismatch;
  logic [ADDR_WIDTH-1:0] w_addr_inc;

  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [DATA_WIDTH-1:0] seed,
    input logic [ADDR_WIDTH-1:0] a,
    input logic                  ph
  );
    logic [DATA_WIDTH-1:0] v;
    v = seed + DATA_WIDTH'(a);
    return ph ? ~v : v;
  endfunction

  assign w_last     = (r_address == {ADDR_WIDTH{1'b1}});
  assign w_addr_inc = r_address + 1'b1;
  // OUT is combinational from the registered address, so it is valid by the end of the READ cycle
  assign w_mismatch = (i_out != pattern(r_seed, r_address, r_phase));

  always_comb begin
    w_state      = r_state;
    w_phase      = r_phase;
    w_seed       = r_seed;
    w_address    = r_address;
    w_in         = r_in;
    w_load       = 1'b0;
    w_err        = r_err;
    w_fail_addr  = r_fail_addr;
    w_fail_phase = r_fail_phase;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state      = S_WRITE;
          w_seed       = i_seed;
          w_phase      = 1'b0;
          w_address    = '0;
          w_in         = pattern(i_seed, '0, 1'b0);
          w_load       = 1'b1;
          w_err        = '0;
          w_fail_addr  = '0;
          w_fail_phase = 1'b0;
        end
      end
      S_WRITE: begin
        if (w_last) begin
          w_state   = S_READ;
          w_address = '0;
        end else begin
          w_address = w_addr_inc;
          w_in      = pattern(r_seed, w_addr_inc, r_phase);
          w_load    = 1'b1;
        end
      end
      S_READ: begin
        if (w_mismatch) begin
          if (r_err != ERR_MAX) w_err = r_err + 1'b1;
          if (r_err == '0) begin
            w_fail_addr  = r_address;
            w_fail_phase = r_phase;
          end
        end
        if (w_last) begin
          w_address = '0;
          if (!r_phase) begin
            w_state = S_WRITE;
            w_phase = 1'b1;
            w_in    = pattern(r_seed, '0, 1'b1);
            w_load  = 1'b1;
          end else begin
            w_state = S_DONE;
          end
        end else begin
          w_address = w_addr_inc;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_phase      <= 1'b0;
      r_seed       <= '0;
      r_address    <= '0;
      r_in         <= '0;
      r_load       <= 1'b0;
      r_err        <= '0;
      r_fail_addr  <= '0;
      r_fail_phase <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_phase      <= w_phase;
      r_seed       <= w_seed;
      r_address    <= w_address;
      r_in         <= w_in;
      r_load       <= w_load;
      r_err        <= w_err;
      r_fail_addr  <= w_fail_addr;
      r_fail_phase <= w_fail_phase;
    end
  end

  assign o_address      = r_address;
  assign o_in           = r_in;
  assign o_load         = r_load;
  assign o_busy         = (r_state == S_WRITE) || (r_state == S_READ);
  assign o_done         = (r_state == S_DONE);
  assign o_pass         = o_done && (r_err == '0);
  assign o_error_count  = r_err;
  assign o_fail_address = r_fail_addr;
  assign o_fail_phase   = r_fail_phase;

endmodule

// File: tb/tb_ram8_bist.sv
// tb/tb_ram8_bist.sv - self-checking bench for ram8_bist
// RAM8 model with a stuck-at-0 read mask; results predicted from the pattern rule.
module tb_ram8_bist;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_seed = '0;
  logic [2:0]  o_address;
  logic [15:0] o_in;
  logic        o_load;
  logic [15:0] i_out;
  logic        o_busy, o_done, o_pass;
  logic [4:0]  o_error_count;
  logic [2:0]  o_fail_address;
  logic        o_fail_phase;

  logic [15:0] mem [0:7];
  logic [15:0] stuck_mask = '0;
  logic [18:0] wlog[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram8_bist dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_seed        (i_seed),
    .o_address     (o_address),
    .o_in          (o_in),
    .o_load        (o_load),
    .i_out         (i_out),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_pass        (o_pass),
    .o_error_count (o_error_count),
    .o_fail_address(o_fail_address),
    .o_fail_phase  (o_fail_phase)
  );

  assign i_out = mem[o_address] & ~stuck_mask;

  always @(posedge clk) begin
    if (o_load) begin
      mem[o_address] <= o_in;
      wlog.push_back({o_address, o_in});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_test(input logic [15:0] seed, input logic [15:0] mask, input int pulse_at);
    logic [18:0] exp_log[$];
    logic [15:0] pat;
    int exp_err, exp_fa, exp_fp, cycles, busy_n;
    bit seen;
    exp_err = 0; exp_fa = 0; exp_fp = 0; seen = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < 8; a++) begin
        pat = seed + 16'(a);
        if (ph == 1) pat = ~pat;
        exp_log.push_back({3'(a), pat});
        if ((pat & mask) != 16'h0) begin
          if (!seen) begin
            exp_fa = a; exp_fp = ph; seen = 1;
          end
          if (exp_err < 16) exp_err++;
        end
      end
    end
    stuck_mask = mask;
    wlog.delete();
    @(negedge clk);
    i_seed  = seed;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cycles  = 1;
    busy_n  = 0;
    check("start_load", 32'(o_load), 32'd1);
    check("start_addr", 32'(o_address), 32'd0);
    check("start_cleared", 32'({o_error_count, o_fail_address, o_fail_phase}), 32'd0);
    while (!o_done && cycles < 100) begin
      if (o_busy) busy_n++;
      i_start = (cycles == pulse_at);
      @(negedge clk);
      cycles++;
    end
    i_start = 1'b0;
    check("done_latency", 32'(cycles), 32'd33);
    check("busy_span", 32'(busy_n), 32'd32);
    check("busy_at_done", 32'(o_busy), 32'd0);
    check("load_at_done", 32'(o_load), 32'd0);
    check("error_count", 32'(o_error_count), 32'(exp_err));
    check("pass", 32'(o_pass), 32'(exp_err == 0));
    check("fail_address", 32'(o_fail_address), 32'(exp_fa));
    check("fail_phase", 32'(o_fail_phase), 32'(exp_fp));
    check("write_count", 32'(wlog.size()), 32'd16);
    for (int k = 0; k < 16 && k < wlog.size(); k++)
      check($sformatf("write%0d", k), 32'(wlog[k]), 32'(exp_log[k]));
  endtask

  task automatic reset_mid_test();
    bit saw_done;
    saw_done = 0;
    stuck_mask = '0;
    @(negedge clk);
    i_seed  = 16'h5a5a;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (9) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check("rst_mid_load", 32'(o_load), 32'd0);
    check("rst_mid_busy", 32'(o_busy), 32'd0);
    check("rst_mid_addr", 32'(o_address), 32'd0);
    check("rst_mid_errs", 32'(o_error_count), 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_done || o_busy) saw_done = 1;
    end
    check("no_done_after_reset", 32'(saw_done), 32'd0);
  endtask

  initial begin
    logic [15:0] rseed, rmask;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    check("reset_addr", 32'(o_address), 32'd0);
    check("reset_in", 32'(o_in), 32'd0);
    check("reset_ctl", 32'({o_load, o_busy, o_done, o_pass}), 32'd0);
    check("reset_errs", 32'(o_error_count), 32'd0);

    run_test(16'h1234, 16'h0000, -1);
    run_test(16'h1234, 16'h0001, -1);
    run_test(16'h0000, 16'h0000, -1);
    run_test(16'hFFFC, 16'h0000, -1);
    run_test(16'h0F0F, 16'h0000, 5);
    for (int i = 0; i < 6; i++) begin
      rseed = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       rmask = 16'h0000;
        1:       rmask = 16'(32'd1 << $urandom_range(0, 15));
        default: rmask = 16'($urandom);
      endcase
      run_test(rseed, rmask, -1);
    end
    reset_mid_test();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
